// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared parameters and FSM state type for the 128x48 SRAM arbiter
package sram_arb_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 48;
  localparam int DEPTH     = 128;
  localparam int NUM_REQ   = 2;
  localparam int NUM_BYTES = DATA_W / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant with its own pointer register
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // The pointer only matters on a collision; a lone requester wins outright.
  always_comb begin
    gnt = '0;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram_arb128x48.sv
// rtl/sram_arb128x48.sv - scrubbing two-port arbiter in front of a 128x48 synchronous SRAM
module sram_arb128x48
  import sram_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*NUM_BYTES-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          init_done,
  output logic                          sram_csb,
  output logic                          sram_web,
  output logic                          sram_oeb,
  output logic [ADDR_W-1:0]             sram_a,
  output logic [DATA_W-1:0]             sram_i,
  output logic [NUM_BYTES-1:0]          sram_wbm,
  input  logic [DATA_W-1:0]             sram_o
);

  state_e               state_q;
  state_e               state_d;
  logic [ADDR_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]    cnt_d;
  logic                 init_done_q;
  logic                 init_done_d;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [NUM_REQ-1:0]   rsp_valid_d;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gidx;
  logic                 g_write;
  logic [ADDR_W-1:0]    g_addr;
  logic [DATA_W-1:0]    g_wdata;
  logic [NUM_BYTES-1:0] g_wmask;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == ST_RUN),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign gidx    = gnt[1];
  assign g_write = gidx ? req_write[1] : req_write[0];
  assign g_addr  = gidx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign g_wdata = gidx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign g_wmask = gidx ? req_wmask[2*NUM_BYTES-1:NUM_BYTES] : req_wmask[NUM_BYTES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign init_done_d = (state_d == ST_RUN);
  // The SRAM returns read data one edge after the access, so the response
  // strobe is the grant of a read delayed by one cycle.
  assign rsp_valid_d = gnt & ~req_write;

  // Reset must park the SRAM even though the idle state is INIT, which
  // would otherwise be writing.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_wbm = '0;
    sram_a   = '0;
    sram_i   = '0;
    if (rst_n) begin
      unique case (state_q)
        ST_INIT: begin
          sram_csb = 1'b0;
          sram_web = 1'b0;
          sram_wbm = '1;
          sram_a   = cnt_q;
        end
        ST_RUN: begin
          if (|gnt) begin
            sram_csb = 1'b0;
            sram_web = ~g_write;
            sram_wbm = g_wmask;
            sram_a   = g_addr;
            sram_i   = g_wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = sram_o;
  assign init_done = init_done_q;
  assign sram_oeb  = 1'b0;

endmodule

// File: tb/tb_sram_arb128x48.sv
// tb/tb_sram_arb128x48.sv - randomized self-checking bench with SRAM model and reference scoreboard
module tb_sram_arb128x48;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             req_valid, req_ready, req_write, rsp_valid;
  logic [2*ADDR_W-1:0]    req_addr;
  logic [2*DATA_W-1:0]    req_wdata;
  logic [2*NUM_BYTES-1:0] req_wmask;
  logic [DATA_W-1:0]      rsp_rdata, sram_i, sram_o;
  logic                   init_done, sram_csb, sram_web, sram_oeb;
  logic [ADDR_W-1:0]      sram_a;
  logic [NUM_BYTES-1:0]   sram_wbm;

  logic                 rq_v [2];
  logic                 rq_w [2];
  logic [ADDR_W-1:0]    rq_a [2];
  logic [DATA_W-1:0]    rq_d [2];
  logic [NUM_BYTES-1:0] rq_m [2];

  assign req_valid = {rq_v[1], rq_v[0]};
  assign req_write = {rq_w[1], rq_w[0]};
  assign req_addr  = {rq_a[1], rq_a[0]};
  assign req_wdata = {rq_d[1], rq_d[0]};
  assign req_wmask = {rq_m[1], rq_m[0]};

  sram_arb128x48 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_wbm  (sram_wbm),
    .sram_o    (sram_o)
  );

  // Synchronous SRAM model; powers up with garbage so the scrub matters.
  logic [DATA_W-1:0] mem [DEPTH];
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'({$urandom, $urandom});
      seeded <= 1'b1;
    end else if (!sram_csb) begin
      if (!sram_web) begin
        for (int k = 0; k < NUM_BYTES; k++)
          if (sram_wbm[k]) mem[sram_a][8*k +: 8] <= sram_i[8*k +: 8];
      end else begin
        sram_o <= mem[sram_a];
      end
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_ptr;
  logic [1:0]        exp_rv;
  logic [DATA_W-1:0] exp_rd;
  logic [1:0]        obs_ready, obs_rv;
  logic [DATA_W-1:0] obs_rd;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [NUM_BYTES-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < NUM_BYTES; k++) if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic idle_all();
    for (int n = 0; n < 2; n++) rq_v[n] = 1'b0;
  endtask

  // One bus cycle: entered just after a rising edge with requests set up.
  task automatic cycle();
    logic [1:0] g;
    int idx;
    @(negedge clk);
    if (rq_v[0] && rq_v[1]) g = (ref_ptr == 0) ? 2'b01 : 2'b10;
    else if (rq_v[0])       g = 2'b01;
    else if (rq_v[1])       g = 2'b10;
    else                    g = 2'b00;
    chk("ready", req_ready, g);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != 2'b00) chk("rsp_rdata", rsp_rdata, exp_rd);
    obs_ready = req_ready;
    obs_rv    = rsp_valid;
    obs_rd    = rsp_rdata;
    chk("csb", sram_csb, (g == 2'b00));
    exp_rv = 2'b00;
    if (g != 2'b00) begin
      idx = g[1] ? 1 : 0;
      chk("web", sram_web, !rq_w[idx]);
      chk("addr", sram_a, rq_a[idx]);
      if (rq_w[idx]) begin
        chk("wdata", sram_i, rq_d[idx]);
        chk("wbm", sram_wbm, rq_m[idx]);
        ref_mem[rq_a[idx]] = merge(ref_mem[rq_a[idx]], rq_d[idx], rq_m[idx]);
      end else begin
        exp_rv = g;
        exp_rd = ref_mem[rq_a[idx]];
      end
      ref_ptr = 1 - idx;
    end else begin
      chk("idle_wbm", sram_wbm, '0);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_phase();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      rq_v[n] = 1'b1;
      rq_w[n] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_csb", sram_csb, 1'b1);
      chk("rst_web", sram_web, 1'b1);
      chk("rst_wbm", sram_wbm, '0);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_rsp", rsp_valid, 2'b00);
      chk("rst_done", init_done, 1'b0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  // Follows the scrub cycle by cycle; optionally re-asserts reset midway.
  task automatic scrub(input int abort_at, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      chk("scrub_a", sram_a, k);
      chk("scrub_csb", sram_csb, 1'b0);
      chk("scrub_web", sram_web, 1'b0);
      chk("scrub_wbm", sram_wbm, 6'h3F);
      chk("scrub_i", sram_i, '0);
      chk("scrub_ready", req_ready, 2'b00);
      chk("scrub_done", init_done, 1'b0);
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_csb", sram_csb, 1'b1);
        chk("abort_done", init_done, 1'b0);
        aborted = 1'b1;
        return;
      end
    end
    idle_all();
    @(negedge clk);
    chk("init_done", init_done, 1'b1);
    chk("run_idle_csb", sram_csb, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_ptr = 0;
    exp_rv  = 2'b00;
  endtask

  task automatic one_req(input int n, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NUM_BYTES-1:0] m);
    idle_all();
    rq_v[n] = 1'b1; rq_w[n] = w; rq_a[n] = a; rq_d[n] = d; rq_m[n] = m;
    cycle();
    idle_all();
  endtask

  initial begin
    bit ab;
    logic [ADDR_W-1:0] alist0 [3];
    logic [ADDR_W-1:0] alist1 [3];
    int i0, i1;
    for (int n = 0; n < 2; n++) begin
      rq_v[n] = 1'b0; rq_w[n] = 1'b0; rq_a[n] = '0; rq_d[n] = '0; rq_m[n] = '0;
    end
    ref_ptr = 0; exp_rv = 2'b00; exp_rd = '0;

    reset_phase();
    scrub(-1, ab);

    // Both requesters stream reads right after init: grants must alternate.
    alist0[0] = 7'd0;   alist0[1] = 7'd64; alist0[2] = 7'd127;
    alist1[0] = 7'd127; alist1[1] = 7'd64; alist1[2] = 7'd0;
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      rq_v[0] = (i0 < 3); rq_w[0] = 1'b0; rq_a[0] = alist0[i0 % 3];
      rq_v[1] = (i1 < 3); rq_w[1] = 1'b0; rq_a[1] = alist1[i1 % 3];
      cycle();
      chk("alt_gnt", obs_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("alt_rsp", obs_rv, (k % 2) ? 2'b01 : 2'b10);
        chk("alt_zero", obs_rd, '0);
      end
      if (obs_ready[0]) i0++;
      if (obs_ready[1]) i1++;
    end
    idle_all();
    cycle();
    chk("alt_last_rsp", obs_rv, 2'b10);
    chk("alt_last_zero", obs_rd, '0);

    one_req(0, 1'b1, 7'd5, 48'h0123456789AB, 6'h3F);
    one_req(1, 1'b0, 7'd5, '0, '0);
    cycle();
    chk("wr_rd_valid", obs_rv, 2'b10);
    chk("wr_rd_data", obs_rd, 48'h0123456789AB);

    one_req(0, 1'b1, 7'd9, 48'hFFFFFFFFFFFF, 6'h3F);
    one_req(0, 1'b1, 7'd9, 48'h0, 6'h05);
    one_req(0, 1'b0, 7'd9, '0, '0);
    cycle();
    chk("mask_valid", obs_rv, 2'b01);
    chk("mask_data", obs_rd, 48'hFFFFFF00FF00);

    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rq_v[n] && $urandom_range(0, 2) != 0) begin
          rq_v[n] = 1'b1;
          rq_w[n] = 1'($urandom_range(0, 1));
          rq_a[n] = ADDR_W'($urandom_range(0, 15));
          rq_d[n] = DATA_W'({$urandom, $urandom});
          rq_m[n] = NUM_BYTES'($urandom);
        end
      end
      cycle();
      for (int n = 0; n < 2; n++) if (obs_ready[n]) rq_v[n] = 1'b0;
    end
    idle_all();
    cycle();

    reset_phase();
    scrub(60, ab);
    chk("abort_taken", ab, 1'b1);
    reset_phase();
    scrub(-1, ab);
    chk("full_rescrub", ab, 1'b0);

    // Reset between a read transfer and its response edge drops the response.
    idle_all();
    rq_v[0] = 1'b1; rq_w[0] = 1'b0; rq_a[0] = 7'd3;
    @(negedge clk);
    chk("drop_ready", req_ready, 2'b01);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_rsp", rsp_valid, 2'b00);
    @(posedge clk); #1;
    reset_phase();
    scrub(-1, ab);
    one_req(1, 1'b0, 7'd3, '0, '0);
    cycle();
    chk("post_reset_read", obs_rv, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
